// File: rtl/alu_operand_stage_if.sv
// Bundles the ID/EX-side and ALU-side signals of the operand stage.
// The stage itself connects through the slave modport.
interface alu_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_src1;
    logic [1:0]      alu_src2;
    logic [1:0]      fwd_sel1;
    logic [1:0]      fwd_sel2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] mem_fwd_data;
    logic [XLEN-1:0] wb_fwd_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [XLEN-1:0] store_data;
    logic            sel_err;

    modport master (
        output in_valid, alu_src1, alu_src2, fwd_sel1, fwd_sel2,
               rs1_data, rs2_data, pc, imm, mem_fwd_data, wb_fwd_data,
               flush, out_ready,
        input  in_ready, out_valid, alu_in1, alu_in2, store_data, sel_err
    );

    modport slave (
        input  in_valid, alu_src1, alu_src2, fwd_sel1, fwd_sel2,
               rs1_data, rs2_data, pc, imm, mem_fwd_data, wb_fwd_data,
               flush, out_ready,
        output in_ready, out_valid, alu_in1, alu_in2, store_data, sel_err
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand select/forwarding stage feeding a 2-entry skid buffer.
//   state   | meaning
//   S_EMPTY | no entry held, out_valid=0, in_ready=1
//   S_ONE   | head entry valid, in_ready=1
//   S_FULL  | head and tail valid, in_ready=0
module alu_operand_stage #(
    parameter int          XLEN   = 32,
    parameter int unsigned CONST2 = 4,
    parameter int unsigned CONST1 = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave bus
);
    localparam logic [XLEN-1:0] L_CONST1 = XLEN'(CONST1);
    localparam logic [XLEN-1:0] L_CONST2 = XLEN'(CONST2);

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] st;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_in_ready;
    logic            r_sel_err;
    entry_t          r_head;
    entry_t          r_tail;
    entry_t          w_new;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic            w_push;
    logic            w_pop;
    logic            w_out_valid;
    logic            w_reserved;
    logic            w_load_head;
    logic            w_load_tail;
    logic            w_shift;

    always_comb begin
        w_rs1 = '0;
        case (bus.fwd_sel1)
            2'b00:   w_rs1 = bus.rs1_data;
            2'b01:   w_rs1 = bus.mem_fwd_data;
            2'b10:   w_rs1 = bus.wb_fwd_data;
            default: w_rs1 = '0;
        endcase
    end

    always_comb begin
        w_rs2 = '0;
        case (bus.fwd_sel2)
            2'b00:   w_rs2 = bus.rs2_data;
            2'b01:   w_rs2 = bus.mem_fwd_data;
            2'b10:   w_rs2 = bus.wb_fwd_data;
            default: w_rs2 = '0;
        endcase
    end

    always_comb begin
        w_new = '0;
        case (bus.alu_src1)
            2'b00:   w_new.in1 = w_rs1;
            2'b01:   w_new.in1 = bus.pc;
            2'b10:   w_new.in1 = L_CONST1;
            default: w_new.in1 = '0;
        endcase
        case (bus.alu_src2)
            2'b00:   w_new.in2 = w_rs2;
            2'b01:   w_new.in2 = bus.imm;
            2'b10:   w_new.in2 = L_CONST2;
            default: w_new.in2 = '0;
        endcase
        // store data always carries the forwarded rs2, independent of alu_src2
        w_new.st = w_rs2;
    end

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_push      = bus.in_valid & r_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_reserved  = (&bus.alu_src1) | (&bus.alu_src2) |
                         (&bus.fwd_sel1) | (&bus.fwd_sel2);

    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = S_ONE;
                    w_load_head = 1'b1;
                end
            end
            S_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = S_FULL;
                    w_load_tail = 1'b1;
                end else if (w_push && w_pop) begin
                    w_load_head = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt = S_ONE;
                    w_shift     = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // flush drops everything, including a push arriving in the same cycle
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
            w_load_head = 1'b0;
            w_load_tail = 1'b0;
            w_shift     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= w_new;
            end else if (w_shift) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= w_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_push && w_reserved) begin
            r_sel_err <= 1'b1;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.alu_in1    = r_head.in1;
    assign bus.alu_in2    = r_head.in2;
    assign bus.store_data = r_head.st;
    assign bus.sel_err    = r_sel_err;
endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; CONST2, default 4, constant for alu_src2=2'b10; CONST1, default 0, constant for alu_src1=2'b10.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1 / in_ready  output  1  upstream handshake (ID/EX side).
REQ-005 alu_src1, alu_src2  input  2 each  operand select: src1 00 rs1, 01 pc, 10 CONST1; src2 00 rs2, 01 imm, 10 CONST2; 11 reserved.
REQ-006 fwd_sel1, fwd_sel2  input  2 each  register-operand source: 00 regfile, 01 mem_fwd_data, 10 wb_fwd_data, 11 reserved.
REQ-007 rs1_data, rs2_data, pc, imm, mem_fwd_data, wb_fwd_data  input  XLEN each  candidate data.
REQ-008 flush  input  1  synchronous discard of all buffered entries.
REQ-009 out_valid  output  1 / out_ready  input  1  downstream handshake (ALU side).
REQ-010 alu_in1, alu_in2, store_data  output  XLEN each  selected operands; store_data = forwarded rs2 regardless of alu_src2.
REQ-011 sel_err  output  1  sticky flag: a reserved select was accepted.

Function
REQ-012 Resolved rs1 SHALL be chosen by fwd_sel1, resolved rs2 by fwd_sel2; reserved code yields 0.
REQ-013 alu_in1/alu_in2 candidates SHALL be chosen by alu_src1/alu_src2 from resolved rs1/rs2, pc, imm, constants; reserved code yields 0.
REQ-014 Selection SHALL be combinational on inputs and captured (alu_in1, alu_in2, store_data) only on an input handshake (in_valid & in_ready).
REQ-015 Block SHALL be a 2-entry skid buffer with states EMPTY, ONE, FULL; outputs always driven from the head entry.
REQ-016 in_ready SHALL be a register output, 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-017 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-018 Transitions: EMPTY+push->ONE; ONE+push&!pop->FULL; ONE+pop&!push->EMPTY; ONE+push&pop->ONE (new entry becomes head next cycle); FULL+pop->ONE (second entry becomes head); otherwise hold.
REQ-019 push = in_valid & in_ready; pop = out_valid & out_ready; latency input-accept to out_valid SHALL be 1 cycle from EMPTY.
REQ-020 Entries SHALL be delivered in acceptance order; no entry dropped or duplicated without flush.
REQ-021 While out_valid=1 and out_ready=0, alu_in1, alu_in2, store_data SHALL remain stable even if forwarding inputs change.
REQ-022 flush SHALL, on the next edge, set state EMPTY, in_ready=1, out_valid=0; a push in the same cycle as flush SHALL be discarded.
REQ-023 sel_err SHALL set on a push carrying any reserved alu_src or fwd_sel code, and remain set until reset; flush does not clear it.
REQ-024 Arithmetic SHALL not occur; CONST1/CONST2 truncated/zero-extended to XLEN.

Reset
REQ-025 On rst_n low, immediately: state EMPTY, out_valid=0, in_ready=1, sel_err=0, alu_in1=alu_in2=store_data=0.
REQ-026 Reset assertion mid-transfer SHALL discard all entries; first push after deassertion behaves as from EMPTY.

Verification
REQ-027 Push alu_src1=01, alu_src2=10, pc=0x100 from EMPTY -> next cycle out_valid=1, alu_in1=0x100, alu_in2=4.
REQ-028 fwd_sel1=01, mem_fwd=0xDEAD, fwd_sel2=10, wb_fwd=0xBEEF, alu_src1=00, alu_src2=00 -> alu_in1=0xDEAD, alu_in2=0xBEEF, store_data=0xBEEF; with alu_src2=01 imm=8 -> alu_in2=8, store_data=0xBEEF.
REQ-029 out_ready=0, push A, B -> FULL, in_ready=0 next cycle; change mem_fwd -> outputs stay A; out_ready=1 -> A, then B, then EMPTY.
REQ-030 Simultaneous push/pop in ONE each cycle for 8 cycles -> continuous out_valid=1, order preserved, in_ready stays 1.
REQ-031 FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing delivered.
REQ-032 Push with alu_src1=11 -> alu_in1=0, sel_err=1; flush -> sel_err still 1; rst_n low -> sel_err=0 asynchronously.
